dense_layer_mac: RTL and testbench
==================================

DENSE_LAYER_MAC -- requirements
Module: dense_layer_mac

Interface
REQ-001 SHALL have parameter N_IN, default 4, number of layer inputs (>=1).
REQ-002 SHALL have parameter N_OUT, default 4, number of neurons (>=1).
REQ-003 SHALL have parameter IN_W, default 32, signed activation width.
REQ-004 SHALL have parameter W_W, default 6, signed weight/bias width.
REQ-005 SHALL have parameter ACC_W, default 32, signed accumulator/output width.
REQ-006 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port enable  input  1  global advance; low freezes all state.
REQ-009 SHALL have port in_valid  input  1  x_flat valid.
REQ-010 SHALL have port in_ready  output  1  block can accept x_flat.
REQ-011 SHALL have port x_flat  input  N_IN*IN_W  activations; x[i] at bits [i*IN_W +: IN_W].
REQ-012 SHALL have port w_flat  input  N_IN*N_OUT*W_W  weights; w[i][o] at index i*N_OUT+o.
REQ-013 SHALL have port b_flat  input  N_OUT*W_W  biases; b[o] at index o.
REQ-014 SHALL have port out_valid  output  1  y_flat valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts y_flat.
REQ-016 SHALL have port y_flat  output  N_OUT*ACC_W  results; y[o] at index o.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE using one time-multiplexed multiply-accumulate.
REQ-018 SHALL drive in_ready = enable AND state==IDLE.
REQ-019 SHALL, on in_valid AND in_ready, register x_flat, clear counters i=0, o=0, and enter RUN.
REQ-020 SHALL, per enabled RUN cycle, compute acc_next = (i==0 ? sext(b[o]) : acc) + x[i]*w[i][o], all operands signed.
REQ-021 SHALL form the product at IN_W+W_W bits, then sign-extend or truncate to ACC_W; sums wrap modulo 2^ACC_W.
REQ-022 SHALL, when i==N_IN-1, write acc_next to y[o], set i=0, and increment o; otherwise increment i.
REQ-023 SHALL, on the write with o==N_OUT-1, enter DONE with out_valid=1.
REQ-024 SHALL assert out_valid exactly N_IN*N_OUT enabled cycles after the input handshake (16 at defaults).
REQ-025 SHALL, in DONE, hold y_flat and out_valid stable until out_valid AND out_ready AND enable, then return to IDLE.
REQ-026 SHALL keep in_ready low in RUN and DONE; no input is accepted while a result is pending.
REQ-027 SHALL freeze state, counters, acc, y and out_valid when enable=0; no handshake completes.
REQ-028 SHALL require w_flat and b_flat stable from input handshake to DONE; changes give undefined results.
REQ-029 SHALL keep y_flat unchanged outside RUN writes; prior results persist in IDLE.

Reset
REQ-030 SHALL, with reset high at a clock edge, force state=IDLE, i=o=0, acc=0, y_flat=0, out_valid=0, overriding enable.
REQ-031 SHALL abort any RUN/DONE operation on reset; the partial result is discarded and never presented.
REQ-032 SHALL present in_ready=enable on the first cycle after reset deasserts.

Configuration
REQ-033 SHALL, with macro DENSE_RELU_EN defined, store max(acc_next,0) into y[o] (ReLU activation).
REQ-034 SHALL, without DENSE_RELU_EN, store acc_next unmodified (linear, default generation behaviour).

Structure
REQ-035 SHALL place the FSM state enum and default parameter constants in shared package dense_pkg.
REQ-036 SHALL isolate the signed multiply-add (acc, x, w, bias-select -> acc_next) in sub-module dense_mac_unit, combinational.

Verification
REQ-037 SHALL test defaults: x=(1,2,3,4), all w=1, b=(0,1,-1,5) -> y=(10,11,9,15), out_valid exactly 16 cycles after handshake.
REQ-038 SHALL test sign/ReLU: x=(5,0,0,0), w[0][0]=-1, other w=0, b=0 -> y[0]=-5 without DENSE_RELU_EN, 0 with it.
REQ-039 SHALL test backpressure: out_ready low 10 cycles in DONE -> y_flat, out_valid stable, in_ready=0; handshake then in_ready=1 next cycle.
REQ-040 SHALL test stall: enable low 3 cycles mid-RUN -> out_valid 19 cycles after handshake, results unchanged.
REQ-041 SHALL test reset at RUN cycle 7 -> next cycle out_valid=0, y_flat=0, in_ready=1; new input yields correct result.
REQ-042 SHALL test wrap: x[0]=32'h7FFFFFFF, w[0][0]=31, others 0, b=0 -> y[0]=32'h7FFFFFE1.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared constants and FSM state type for the dense layer MAC.
// Holds default parameter values used by dense_layer_mac.
package dense_pkg;

  localparam int DEF_N_IN  = 4;
  localparam int DEF_N_OUT = 4;
  localparam int DEF_IN_W  = 32;
  localparam int DEF_W_W   = 6;
  localparam int DEF_ACC_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dense_mac_unit.sv
// Combinational signed multiply-add: acc_next = base + x*w,
// base = first ? sext(b) : acc. Ports: acc, x, w, b, first -> acc_next.
module dense_mac_unit #(
  parameter int IN_W  = 32,
  parameter int W_W   = 6,
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [IN_W-1:0]  x,
  input  logic [W_W-1:0]   w,
  input  logic [W_W-1:0]   b,
  input  logic             first,
  output logic [ACC_W-1:0] acc_next
);

  localparam int PW = IN_W + W_W;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_r;
  logic signed [ACC_W-1:0] bext;
  logic signed [ACC_W-1:0] base;

  // Full-width product, then resized (sign-extend or truncate).
  assign prod   = PW'($signed(x)) * PW'($signed(w));
  assign prod_r = ACC_W'(prod);
  assign bext   = ACC_W'($signed(b));
  assign base   = first ? bext : $signed(acc);

  // Wraps modulo 2^ACC_W.
  assign acc_next = base + prod_r;

endmodule

// File: rtl/dense_layer_mac.sv
// Dense layer y[o] = b[o] + sum_i x[i]*w[i][o] with one shared MAC.
// Ports: clock, reset, enable, in_valid/in_ready/x_flat, w_flat, b_flat,
// out_valid/out_ready/y_flat. Option: DENSE_RELU_EN clamps y at zero.
module dense_layer_mac
  import dense_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int N_OUT = DEF_N_OUT,
  parameter int IN_W  = DEF_IN_W,
  parameter int W_W   = DEF_W_W,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN*IN_W-1:0]     x_flat,
  input  logic [N_IN*N_OUT*W_W-1:0] w_flat,
  input  logic [N_OUT*W_W-1:0]     b_flat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_OUT*ACC_W-1:0]   y_flat
);

  localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [IW-1:0] LAST_I = IW'(N_IN - 1);
  localparam logic [OW-1:0] LAST_O = OW'(N_OUT - 1);

  state_t               state;
  logic [IW-1:0]        i;
  logic [OW-1:0]        o;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_next;
  logic [ACC_W-1:0]     yval;
  logic [N_IN*IN_W-1:0] xr;
  logic [31:0]          widx;
  logic [IN_W-1:0]      xi;
  logic [W_W-1:0]       wio;
  logic [W_W-1:0]       bo;

  assign in_ready = enable && (state == IDLE);

  assign widx = 32'(i) * 32'(N_OUT) + 32'(o);
  assign xi   = xr[32'(i) * IN_W +: IN_W];
  assign wio  = w_flat[widx * W_W +: W_W];
  assign bo   = b_flat[32'(o) * W_W +: W_W];

  dense_mac_unit #(
    .IN_W  (IN_W),
    .W_W   (W_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .acc      (acc),
    .x        (xi),
    .w        (wio),
    .b        (bo),
    .first    (i == '0),
    .acc_next (acc_next)
  );

`ifdef DENSE_RELU_EN
  assign yval = acc_next[ACC_W-1] ? '0 : acc_next;
`else
  assign yval = acc_next;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      i         <= '0;
      o         <= '0;
      acc       <= '0;
      xr        <= '0;
      y_flat    <= '0;
      out_valid <= 1'b0;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xr    <= x_flat;
            i     <= '0;
            o     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (i == LAST_I) begin
            y_flat[32'(o) * ACC_W +: ACC_W] <= yval;
            i <= '0;
            if (o == LAST_O) begin
              o         <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              o <= o + 1'b1;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Directed self-checking bench for dense_layer_mac at default sizes.
// Define DENSE_RELU_EN to match an RTL build with ReLU enabled.
module tb_dense_layer_mac;

  logic         clock = 1'b0;
  logic         reset;
  logic         enable;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] x_flat;
  logic [95:0]  w_flat;
  logic [23:0]  b_flat;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] y_flat;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  dense_layer_mac dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_flat    (x_flat),
    .w_flat    (w_flat),
    .b_flat    (b_flat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y_flat    (y_flat)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] yget(input int o);
    return y_flat[o*32 +: 32];
  endfunction

  task automatic set_x(input int x0, input int x1, input int x2,
                       input int x3);
    x_flat = {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
  endtask

  task automatic set_w(input int i, input int o, input int v);
    w_flat[(i*4+o)*6 +: 6] = 6'(v);
  endtask

  task automatic set_b(input int b0, input int b1, input int b2,
                       input int b3);
    b_flat = {6'(b3), 6'(b2), 6'(b1), 6'(b0)};
  endtask

  task automatic load_basic();
    set_x(1, 2, 3, 4);
    w_flat = '0;
    for (int i = 0; i < 4; i++)
      for (int o = 0; o < 4; o++)
        set_w(i, o, 1);
    set_b(0, 1, -1, 5);
  endtask

  task automatic handshake();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Edges from handshake until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic check_basic(input string tag);
    check({tag, "_y0"}, 64'(yget(0)), 64'd10);
    check({tag, "_y1"}, 64'(yget(1)), 64'd11);
    check({tag, "_y2"}, 64'(yget(2)), 64'd9);
    check({tag, "_y3"}, 64'(yget(3)), 64'd15);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [127:0] ysnap;
    reset     = 1'b1;
    enable    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x_flat    = '0;
    w_flat    = '0;
    b_flat    = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_y", 64'(y_flat[63:0] | y_flat[127:64]), 64'd0);
    check("rst_inrdy", 64'(in_ready), 64'd1);

    // Basic layer, latency, then backpressure.
    load_basic();
    handshake();
    wait_done(n);
    check("basic_lat", 64'(n), 64'd16);
    check_basic("basic");
    ysnap = y_flat;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_ov", 64'(out_valid), 64'd1);
      check("bp_inrdy", 64'(in_ready), 64'd0);
    end
    check("bp_ystable", 64'(y_flat == ysnap), 64'd1);
    consume();
    check("bp_ov_clr", 64'(out_valid), 64'd0);
    check("bp_inrdy_set", 64'(in_ready), 64'd1);
    check("persist_y", 64'(y_flat == ysnap), 64'd1);

    // Sign and optional ReLU.
    set_x(5, 0, 0, 0);
    w_flat = '0;
    set_w(0, 0, -1);
    set_b(0, 0, 0, 0);
    handshake();
    wait_done(n);
    check("sign_lat", 64'(n), 64'd16);
`ifdef DENSE_RELU_EN
    check("sign_y0", 64'(yget(0)), 64'd0);
`else
    check("sign_y0", 64'(yget(0)), 64'(32'hFFFF_FFFB));
`endif
    check("sign_y1", 64'(yget(1)), 64'd0);
    consume();

    // Enable stall mid-run.
    load_basic();
    handshake();
    tick(); tick(); tick(); tick(); tick();
    enable = 1'b0;
    check("stall_inrdy", 64'(in_ready), 64'd0);
    tick(); tick(); tick();
    enable = 1'b1;
    n = 8;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    check("stall_lat", 64'(n), 64'd19);
    check_basic("stall");
    enable = 1'b0;
    out_ready = 1'b1;
    tick();
    check("frozen_ov", 64'(out_valid), 64'd1);
    enable = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall_ack", 64'(out_valid), 64'd0);

    // Reset during run.
    set_x(9, 9, 9, 9);
    handshake();
    for (int k = 0; k < 6; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ov", 64'(out_valid), 64'd0);
    check("abort_y", 64'(y_flat[63:0] | y_flat[127:64]), 64'd0);
    check("abort_inrdy", 64'(in_ready), 64'd1);
    load_basic();
    handshake();
    wait_done(n);
    check("abort_lat", 64'(n), 64'd16);
    check_basic("abort");
    consume();

    // Wraparound of the accumulator.
    x_flat = '0;
    x_flat[31:0] = 32'h7FFF_FFFF;
    w_flat = '0;
    set_w(0, 0, 31);
    set_b(0, 0, 0, 0);
    handshake();
    wait_done(n);
    check("wrap_lat", 64'(n), 64'd16);
    check("wrap_y0", 64'(yget(0)), 64'(32'h7FFF_FFE1));
    check("wrap_y3", 64'(yget(3)), 64'd0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
